// File: rtl/uart_out_tx_pkg.sv
// Shared constants for the UART transmit stage: baud defaults, FSM state encoding
// and the parity helper.
package uart_out_tx_pkg;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int BAUD_RATE        = 9600;
    localparam int DEF_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic byte_parity(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_out_tx_baud_tick.sv
// Bit-period counter: counts enabled cycles 0..CLKS_PER_BIT-1 and flags the last one.
module uart_out_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign tick = en && !restart && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_out_tx.sv
// UART transmitter: one byte per out_start/out_finish handshake, framed as
// start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_out_tx
    import uart_out_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] out_data,
    input  logic       out_start,
    output logic       out_finish,
    output logic       tx
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       finish_q, finish_d;
    logic       rearm_q, rearm_d;
    logic       accept, tick;

    // Re-arm blocks a level-held out_start from launching a second frame.
    assign accept = enable && out_start && rearm_q && (state_q == ST_IDLE);

    uart_out_tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (enable && (state_q != ST_IDLE)),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        finish_d  = finish_q;
        rearm_d   = rearm_q;

        if (enable && !out_start)
            rearm_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d  = out_data;
                    parity_d = byte_parity(out_data, PARITY_ODD != 0);
                    rearm_d  = 1'b0;
                    finish_d = 1'b0;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                // bit_idx doubles as the stop-bit counter here.
                if (tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        finish_d  = 1'b1;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_d     = 1'b1;
                finish_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            finish_q  <= 1'b1;
            rearm_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            finish_q  <= finish_d;
            rearm_q   <= rearm_d;
        end
    end

    assign tx         = tx_q;
    assign out_finish = finish_q;

endmodule

// File: tb/tb_uart_out_tx.sv
// Bench for uart_out_tx: vector table of single frames across four parameter sets,
// a receiver-driven scoreboard, and hand sequences for hold, drain, enable and reset.
module tb_uart_out_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset, enable, out_start;
    logic [7:0] out_data;
    logic       tx_m, fin_m, tx_pe, fin_pe, tx_po, fin_po, tx_s2, fin_s2;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_out_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .out_data(out_data),
        .out_start(out_start), .out_finish(fin_m), .tx(tx_m));
    uart_out_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
        .clk(clk), .reset(reset), .enable(enable), .out_data(out_data),
        .out_start(out_start), .out_finish(fin_pe), .tx(tx_pe));
    uart_out_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
        .clk(clk), .reset(reset), .enable(enable), .out_data(out_data),
        .out_start(out_start), .out_finish(fin_po), .tx(tx_po));
    uart_out_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_s2 (
        .clk(clk), .reset(reset), .enable(enable), .out_data(out_data),
        .out_start(out_start), .out_finish(fin_s2), .tx(tx_s2));

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Receiver on the main instance: counts enabled edges so stretched bits still decode.
    initial begin
        logic       rx_busy;
        int         rx_ph, rx_last;
        logic [9:0] rx_bits;
        logic [7:0] exp_b;
        rx_busy = 1'b0; rx_ph = 0; rx_last = -1; rx_bits = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (tx_m === 1'b0) begin
                    rx_busy = 1'b1; rx_ph = 0; rx_last = -1;
                end
            end else if ((rx_ph % C) == C / 2 && (rx_ph / C) != rx_last) begin
                rx_last = rx_ph / C;
                rx_bits[rx_last] = tx_m;
                if (rx_last == 9) begin
                    rx_busy = 1'b0;
                    check("rx_stop", rx_bits[9], 1'b1);
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL rx_extra: got %0h expected no frame", rx_bits[8:1]);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("rx_byte", rx_bits[8:1], exp_b);
                    end
                end
            end
            @(posedge clk);
            if (rx_busy && enable) rx_ph++;
        end
    end

    logic [127:0] cap_m, cap_pe, cap_po;
    int low_m, low_pe, low_po, low_s2;

    task automatic capture(input int n, input int dis_at, input int en_at);
        cap_m = '0; cap_pe = '0; cap_po = '0;
        low_m = 0; low_pe = 0; low_po = 0; low_s2 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_m[k] = tx_m; cap_pe[k] = tx_pe; cap_po[k] = tx_po;
            if (!fin_m)  low_m++;
            if (!fin_pe) low_pe++;
            if (!fin_po) low_po++;
            if (!fin_s2) low_s2++;
            if (k == dis_at) enable = 1'b0;
            if (k == en_at)  enable = 1'b1;
        end
    endtask

    function automatic logic [127:0] exp_frame(input logic [7:0] d, input int sb, input int extra);
        logic [127:0] v;
        int pos;
        logic b;
        v = '1; pos = 0;
        for (int i = 0; i < 10; i++) begin
            b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            for (int j = 0; j < C + ((i == sb) ? extra : 0); j++) begin
                v[pos] = b; pos++;
            end
        end
        return v;
    endfunction

    task automatic pulse(input logic [7:0] d);
        @(posedge clk); #1;
        out_data = d; out_start = 1'b1;
        @(posedge clk); #1;
        out_start = 1'b0; out_data = ~d;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(fin_m && fin_pe && fin_po && fin_s2) && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", t);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_e;
        logic       par_o;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [127:0] e;
        int bad_tx, bad_f, edges, falls, cyc, first;
        logic prev, fin_pre;
        logic [7:0] fifo[$];

        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b0};

        reset = 1'b1; enable = 1'b1; out_start = 1'b0; out_data = 8'h00;
        @(negedge clk);
        check("reset_tx", tx_m, 1'b1);
        check("reset_fin", fin_m, 1'b1);
        @(posedge clk); #1 reset = 1'b0;

        bad_tx = 0; bad_f = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_m !== 1'b1) bad_tx++;
            if (fin_m !== 1'b1) bad_f++;
        end
        check("idle_tx_bad_cycles", bad_tx, 0);
        check("idle_fin_bad_cycles", bad_f, 0);

        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].data);
            pulse(vecs[i].data);
            capture(60, -1, -1);
            e = exp_frame(vecs[i].data, -1, 0);
            check("tx_seq", cap_m[59:0], e[59:0]);
            check("fin_low_p0", low_m, 40);
            check("fin_low_par", low_pe, 44);
            check("fin_low_s2", low_s2, 48);
            check("par_even", cap_pe[9*C+2], vecs[i].par_e);
            check("par_odd", cap_po[9*C+2], vecs[i].par_o);
            wait_idle();
        end

        // out_start held high: one frame only; a one-cycle drop re-arms it.
        @(posedge clk); #1;
        out_data = 8'h3C; out_start = 1'b1;
        sb_q.push_back(8'h3C);
        falls = 0; prev = fin_m;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (prev && !fin_m) falls++;
            prev = fin_m;
        end
        check("held_one_frame", falls, 1);
        @(posedge clk); #1 out_start = 1'b0;
        @(posedge clk); #1 out_start = 1'b1;
        sb_q.push_back(8'h3C);
        @(negedge clk);
        check("rearm_no_early_start", fin_m, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rearm_start_fin", fin_m, 1'b0);
        check("rearm_start_tx", tx_m, 1'b0);
        out_start = 1'b0;
        wait_idle();

        // Drain-controller model: drops out_start once it sees out_finish=1 at an edge.
        fifo = '{8'h01, 8'h02, 8'h03};
        cyc = 0; first = -1;
        @(posedge clk); #1;
        out_data = fifo[0]; out_start = 1'b1;
        while ((fifo.size() > 0 || !fin_m) && cyc < 400) begin
            @(negedge clk); fin_pre = fin_m;
            @(posedge clk); #1; cyc++;
            if (out_start && fin_pre) begin
                sb_q.push_back(fifo.pop_front());
                out_start = 1'b0;
                if (first < 0) first = cyc;
            end else if (!out_start && fifo.size() > 0) begin
                out_data = fifo[0]; out_start = 1'b1;
            end
        end
        check("drain_no_timeout", cyc < 400, 1'b1);
        check("drain_span", cyc - first, 3 * 10 * C + 2);
        wait_idle();

        // enable low for 7 edges inside data bit 3.
        sb_q.push_back(8'h5A);
        pulse(8'h5A);
        capture(80, 17, 24);
        e = exp_frame(8'h5A, 4, 7);
        check("tx_seq_stretch", cap_m[79:0], e[79:0]);
        check("fin_low_stretch", low_m, 47);
        wait_idle();

        // Reset mid-frame: outputs return high at once, frame abandoned.
        pulse(8'h3C);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_tx", tx_m, 1'b1);
        check("midreset_fin", fin_m, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        edges = 0; prev = tx_m;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_m !== prev) edges++;
            prev = tx_m;
        end
        check("post_reset_tx_edges", edges, 0);
        check("post_reset_fin", fin_m, 1'b1);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
